// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//
// Receives 8N1 serial frames (one start bit, eight data bits LSB-first, one
// stop bit) from the RXD pin and presents each byte through a one-entry
// holding register with a valid/ready handshake. Framing errors and overruns
// are reported as sticky flags for the UART status word.
//
// Parameters:
//   clk_freq_hz : input clock frequency in Hz
//   baud_rate   : serial line rate in bits/s
//   CPB = clk_freq_hz / baud_rate clock cycles per bit (must be >= 4)
//
// Ports:
//   i_clk       : single clock, all flops on its rising edge
//   i_rst_n     : asynchronous active-low reset
//   i_rx        : serial line, idle high, asynchronous to i_clk
//   o_data      : received byte (holding register)
//   o_valid     : o_data holds an unconsumed byte
//   i_ready     : consumer takes the byte in any cycle with o_valid && i_ready
//   o_frame_err : sticky, stop bit was sampled low
//   o_overrun   : sticky, a byte was dropped because the holding register was full
//   i_clr_err   : synchronous clear of both sticky flags (a set event wins)
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int unsigned clk_freq_hz = 100000000,
    parameter int unsigned baud_rate   = 1000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    input  logic       i_clr_err
);

    localparam int unsigned CPB   = clk_freq_hz / baud_rate;
    localparam int unsigned HALF  = CPB / 2;
    localparam int unsigned CNT_W = $clog2(CPB);

    // Last count of a full bit period and of the half-bit start qualification.
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // Synchronizer flops; both reset to the idle line level.
    logic             rx_meta_r;
    logic             rx_sync_r;
    logic             rx_s;

    // Receive state machine and its datapath.
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_nxt_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nxt_s;

    // Holding register and sticky flags.
    logic [7:0]       data_r;
    logic             valid_r;
    logic             frame_err_r;
    logic             overrun_r;

    // Per-cycle events decoded from the state machine.
    logic             stop_sample_s;
    logic             deliver_s;
    logic             frame_set_s;
    logic             load_s;
    logic             overrun_set_s;
    logic             consume_s;

    // Two-flop synchronizer bringing the asynchronous line into the clock domain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= i_rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    assign rx_s = rx_sync_r;

    // State register together with the bit counter, bit index and shift register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
        end
    end

    // Next-state logic: start qualification at half a bit, then one sample per bit centre.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        case (state_r)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nxt_s = ST_START;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == CNT_HALF_END) begin
                    cnt_nxt_s = CNT_ZERO;
                    if (!rx_s) begin
                        state_nxt_s   = ST_DATA;
                        bit_idx_nxt_s = 3'd0;
                    end else begin
                        // Line went back high before mid-bit: treat as a glitch.
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_BIT_END) begin
                    // Right shift so the first (LSB) bit ends up in bit 0 after eight samples.
                    shift_nxt_s   = {rx_s, shift_r[7:1]};
                    cnt_nxt_s     = CNT_ZERO;
                    bit_idx_nxt_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_r == CNT_BIT_END) begin
                    cnt_nxt_s = CNT_ZERO;
                    if (rx_s) begin
                        // Back to IDLE half a bit early so a back-to-back start edge is caught.
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_BREAK;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_BREAK: begin
                // A line held low must return high before a new start can be recognised.
                if (rx_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BREAK;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                cnt_nxt_s     = CNT_ZERO;
                bit_idx_nxt_s = 3'd0;
                shift_nxt_s   = 8'd0;
            end
        endcase
    end

    // Output decode: stop-bit events and their effect on the holding register.
    always_comb begin
        stop_sample_s = (state_r == ST_STOP) && (cnt_r == CNT_BIT_END);
        deliver_s     = stop_sample_s && rx_s;
        frame_set_s   = stop_sample_s && !rx_s;
        // A full holding register may still accept the byte if it is consumed this cycle.
        load_s        = deliver_s && (!valid_r || i_ready);
        overrun_set_s = deliver_s && valid_r && !i_ready;
        consume_s     = valid_r && i_ready && !deliver_s;
    end

    // Holding register with valid/ready handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_r  <= 8'd0;
            valid_r <= 1'b0;
        end else begin
            if (load_s) begin
                data_r  <= shift_r;
                valid_r <= 1'b1;
            end else if (consume_s) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    // Sticky error flags; a set event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (frame_set_s) begin
                frame_err_r <= 1'b1;
            end else if (i_clr_err) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (i_clr_err) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign o_data      = data_r;
    assign o_valid     = valid_r;
    assign o_frame_err = frame_err_r;
    assign o_overrun   = overrun_r;

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//
// Self-checking bench for uart_receiver with default parameters (CPB = 100).
// Stimulus tasks push the bytes that should come out into a scoreboard queue;
// a monitor pops and compares on every o_valid && i_ready handshake.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int CPB  = 100;
    localparam int HALF = CPB / 2;
    // Edge (counted from the first clock edge that sees the start bit) at
    // which the stop bit is sampled and the byte is delivered.
    localparam int DELIVER_EDGE = 2 + HALF + 9 * CPB;

    logic       clk;
    logic       i_rst_n;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_frame_err;
    logic       o_overrun;
    logic       i_clr_err;

    int         n_checks;
    int         n_fail;
    logic [7:0] exp_q[$];
    logic       model_fe;

    uart_receiver #(
        .clk_freq_hz(100000000),
        .baud_rate  (1000000)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun),
        .i_clr_err  (i_clr_err)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock, landing 2 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one 8N1 frame: start, 8 data bits LSB-first, stop (stop_bit chooses its level).
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                i_rx = 1'b0;
            end else if (i == 9) begin
                i_rx = stop_bit;
            end else begin
                i_rx = b[i-1];
            end
            repeat (CPB) tick();
        end
    endtask

    // Consumer: takes each byte ten cycles after it becomes valid, for a fixed cycle budget.
    task automatic run_consumer(input int cycles);
        int wait_cnt;
        wait_cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            i_ready = 1'b0;
            if (o_valid) begin
                if (wait_cnt == 10) begin
                    i_ready  = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
            tick();
        end
        i_ready = 1'b0;
    endtask

    task automatic pulse_ready();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected byte.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (i_rst_n && o_valid && i_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got byte 0x%0h, expected none at %0t", o_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (o_data !== e) begin
                        n_fail++;
                        $display("FAIL sb_data: got 0x%0h, expected 0x%0h at %0t", o_data, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        logic       bad;
        int         gap;
        n_checks  = 0;
        n_fail    = 0;
        model_fe  = 1'b0;
        i_rst_n   = 1'b0;
        i_rx      = 1'b1;
        i_ready   = 1'b0;
        i_clr_err = 1'b0;
        repeat (3) tick();
        check("rst_data", {24'd0, o_data}, 32'h0);
        check("rst_valid", {31'd0, o_valid}, 32'h0);
        check("rst_frame_err", {31'd0, o_frame_err}, 32'h0);
        check("rst_overrun", {31'd0, o_overrun}, 32'h0);
        i_rst_n = 1'b1;
        repeat (10) tick();

        // Single byte: exact delivery edge, hold, then one-cycle consume.
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (DELIVER_EDGE) tick();
                check("single_valid_before", {31'd0, o_valid}, 32'h0);
                tick();
                check("single_valid_after", {31'd0, o_valid}, 32'h1);
                check("single_data", {24'd0, o_data}, 32'h55);
            end
        join
        repeat (30) tick();
        check("single_hold", {31'd0, o_valid}, 32'h1);
        pulse_ready();
        check("single_consumed", {31'd0, o_valid}, 32'h0);
        repeat (20) tick();

        // Back-to-back frames consumed by the auto consumer.
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hA3);
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
                send_frame(8'hA3, 1'b1);
            end
            run_consumer(3 * 10 * CPB + 100);
        join
        check("b2b_drained", exp_q.size(), 32'd0);
        check("b2b_frame_err", {31'd0, o_frame_err}, 32'h0);
        check("b2b_overrun", {31'd0, o_overrun}, 32'h0);

        // Short low glitch on an idle line.
        i_rx = 1'b0;
        repeat (20) tick();
        i_rx = 1'b1;
        repeat (200) tick();
        check("glitch_valid", {31'd0, o_valid}, 32'h0);
        check("glitch_frame_err", {31'd0, o_frame_err}, 32'h0);
        check("glitch_overrun", {31'd0, o_overrun}, 32'h0);

        // Framing error followed by a held-low line, then a good frame.
        send_frame(8'h3C, 1'b0);
        repeat (500) tick();
        i_rx = 1'b1;
        repeat (20) tick();
        check("fe_set", {31'd0, o_frame_err}, 32'h1);
        check("fe_no_valid", {31'd0, o_valid}, 32'h0);
        exp_q.push_back(8'h81);
        fork
            send_frame(8'h81, 1'b1);
            run_consumer(10 * CPB + 50);
        join
        check("fe_next_drained", exp_q.size(), 32'd0);
        check("fe_sticky", {31'd0, o_frame_err}, 32'h1);
        pulse_clr();
        check("fe_cleared", {31'd0, o_frame_err}, 32'h0);
        repeat (10) tick();

        // Overrun: second and third bytes dropped; clear loses to a same-cycle set.
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("ovr_data", {24'd0, o_data}, 32'h11);
        check("ovr_valid", {31'd0, o_valid}, 32'h1);
        check("ovr_flag", {31'd0, o_overrun}, 32'h1);
        fork
            send_frame(8'h33, 1'b1);
            begin
                repeat (DELIVER_EDGE) tick();
                pulse_clr();
                check("ovr_set_wins", {31'd0, o_overrun}, 32'h1);
            end
        join
        check("ovr_data_kept", {24'd0, o_data}, 32'h11);
        pulse_clr();
        check("ovr_cleared", {31'd0, o_overrun}, 32'h0);
        pulse_ready();
        check("ovr_consumed", {31'd0, o_valid}, 32'h0);
        repeat (10) tick();

        // Consume in the exact cycle the second byte is delivered.
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            begin
                repeat (10 * CPB + DELIVER_EDGE) tick();
                pulse_ready();
                check("simul_data", {24'd0, o_data}, 32'h22);
                check("simul_valid", {31'd0, o_valid}, 32'h1);
                check("simul_overrun", {31'd0, o_overrun}, 32'h0);
            end
        join
        repeat (10) tick();

        // Reset in the middle of a frame while a byte is still held.
        fork
            send_frame(8'hF8, 1'b1);
            begin
                repeat (400) tick();
                i_rst_n = 1'b0;
                exp_q.delete();
                #1;
                check("rstmid_data", {24'd0, o_data}, 32'h0);
                check("rstmid_valid", {31'd0, o_valid}, 32'h0);
                check("rstmid_frame_err", {31'd0, o_frame_err}, 32'h0);
                check("rstmid_overrun", {31'd0, o_overrun}, 32'h0);
                repeat (20) tick();
                i_rst_n = 1'b1;
            end
        join
        repeat (50) tick();
        check("rstmid_no_byte", {31'd0, o_valid}, 32'h0);
        exp_q.push_back(8'h7E);
        fork
            send_frame(8'h7E, 1'b1);
            run_consumer(10 * CPB + 50);
        join
        check("rstmid_next_drained", exp_q.size(), 32'd0);

        // Randomized frames with random idle gaps and occasional bad stop bits.
        model_fe = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    b   = 8'($urandom_range(0, 255));
                    bad = ($urandom_range(0, 3) == 0);
                    if (bad) begin
                        model_fe = 1'b1;
                    end else begin
                        exp_q.push_back(b);
                    end
                    send_frame(b, !bad);
                    i_rx = 1'b1;
                    gap  = $urandom_range(5, 40);
                    repeat (gap) tick();
                end
            end
            run_consumer(6 * (10 * CPB + 40) + 100);
        join
        check("rand_drained", exp_q.size(), 32'd0);
        check("rand_frame_err", {31'd0, o_frame_err}, {31'd0, model_fe});
        check("rand_overrun", {31'd0, o_overrun}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
